enc16x4_seq: RTL and testbench



---
 rtl/enc16x4_seq.sv | 91 +++++++++
 tb/tb_enc16x4_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/enc16x4_seq.sv
// Sequential 16-to-4 encoder: captures a request vector and emits the index of
// each set bit in priority order, one per out_valid/out_ready handshake.
module enc16x4_seq #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        load,
  output logic        in_ready,
  output logic [3:0]  code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  count,
  output logic        done
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state;
  logic [15:0] pending;
  logic [15:0] hit;
  logic        last;

  function automatic logic [4:0] popcnt(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  // Later loop iterations override earlier ones, so scan order picks the winner.
  always_comb begin
    code = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 16; i++)
        if (pending[i]) code = 4'(i);
    end else begin
      for (int i = 15; i >= 0; i--)
        if (pending[i]) code = 4'(i);
    end
  end

  assign hit  = 16'd1 << code;
  assign last = (pending & ~hit) == 16'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      count     <= '0;
      done      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            pending <= req;
            count   <= popcnt(req);
            if (req != 16'd0) begin
              state     <= EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            pending <= pending & ~hit;
            if (last) begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc16x4_seq.sv
// Bench for enc16x4_seq: LSB-first and MSB-first instances run in lockstep on
// shared stimulus; expected codes come from a queue-based scoreboard.
module tb_enc16x4_seq;

  logic        clk, rst, load, out_ready;
  logic [15:0] req;
  logic        in_ready0, out_valid0, done0, in_ready1, out_valid1, done1;
  logic [3:0]  code0, code1;
  logic [4:0]  count0, count1;

  enc16x4_seq #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .load(load), .in_ready(in_ready0),
    .code(code0), .out_valid(out_valid0), .out_ready(out_ready),
    .count(count0), .done(done0));

  enc16x4_seq #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .load(load), .in_ready(in_ready1),
    .code(code1), .out_valid(out_valid1), .out_ready(out_ready),
    .count(count1), .done(done1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] req;
    int          cnt;
    int          stall;
    bit          poke;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          q0[$];
  int          q1[$];
  logic [15:0] recon0, recon1;
  vec_t        tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid_lockstep", 32'(out_valid1), 32'(out_valid0));
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) chk("extra_code_lsb", 1, 0);
        else chk("code_lsb", 32'(code0), q0.pop_front());
        recon0 = recon0 | (16'd1 << code0);
      end
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) chk("extra_code_msb", 1, 0);
        else chk("code_msb", 32'(code1), q1.pop_front());
        recon1 = recon1 | (16'd1 << code1);
      end
      if (done0) done_cnt++;
    end
  end

  task automatic run_vec(input vec_t v);
    int n, cyc, d0;
    n = v.cnt;
    @(posedge clk); #1;
    chk("in_ready_before_load", 32'(in_ready0), 1);
    recon0 = '0;
    recon1 = '0;
    for (int i = 0; i < 16; i++)
      if (v.req[i]) begin
        q0.push_back(i);
        q1.push_front(i);
      end
    req       = v.req;
    load      = 1'b1;
    out_ready = (v.stall == 0);
    d0        = done_cnt;
    @(posedge clk); #1;
    if (v.poke) req = 16'hFFFF;
    else load = 1'b0;
    chk("count_lsb", 32'(count0), n);
    chk("count_msb", 32'(count1), n);
    if (n == 0) begin
      chk("empty_done", 32'(done0), 1);
      chk("empty_no_valid", 32'(out_valid0), 0);
    end else begin
      chk("valid_after_load", 32'(out_valid0), 1);
      chk("busy_not_ready", 32'(in_ready0), 0);
      if (v.stall > 0) begin
        for (int s = 0; s < v.stall; s++) begin
          @(negedge clk);
          chk("stall_code_lsb", 32'(code0), q0[0]);
          chk("stall_code_msb", 32'(code1), q1[0]);
          chk("stall_valid", 32'(out_valid0), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
      cyc = 0;
      while (!done0 && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      load = 1'b0;
      chk("done_seen", 32'(done0), 1);
      if (v.stall == 0) chk("emit_cycles", cyc, n);
    end
    chk("idle_ready", 32'(in_ready0), 1);
    chk("idle_no_valid", 32'(out_valid0), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done0), 0);
    chk("done_pulses", done_cnt - d0, 1);
    chk("queue_drained", q0.size() + q1.size(), 0);
    chk("count_held", 32'(count0), n);
    if (n > 0) begin
      chk("recon_lsb", 32'(recon0), 32'(v.req));
      chk("recon_msb", 32'(recon1), 32'(v.req));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   d0;
    vec_t rv;
    tbl[0] = '{16'h8001, 2,  0, 1'b0};
    tbl[1] = '{16'h0124, 3,  0, 1'b0};
    tbl[2] = '{16'hFFFF, 16, 0, 1'b0};
    tbl[3] = '{16'h0030, 2,  5, 1'b0};
    tbl[4] = '{16'h0000, 0,  0, 1'b0};
    tbl[5] = '{16'h0101, 2,  0, 1'b1};
    tbl[6] = '{16'hA5A5, 8,  0, 1'b0};
    tbl[7] = '{16'h8000, 1,  0, 1'b0};

    rst = 1'b1; load = 1'b0; req = '0; out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready0), 1);
    chk("rst_out_valid", 32'(out_valid0), 0);
    chk("rst_code", 32'(code0), 0);
    chk("rst_count", 32'(count0), 0);
    chk("rst_done", 32'(done0), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    for (int r = 0; r < 4; r++) begin
      rv.req   = 16'($urandom);
      rv.cnt   = $countones(rv.req);
      rv.stall = r;
      rv.poke  = 1'b0;
      run_vec(rv);
    end

    // Asynchronous reset in the middle of a vector, after its first code.
    out_ready = 1'b1;
    @(posedge clk); #1;
    req  = 16'h00F0;
    load = 1'b1;
    for (int i = 4; i < 8; i++) begin
      q0.push_back(i);
      q1.push_front(i);
    end
    d0 = done_cnt;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_code", 32'(code0), 5);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid0), 0);
    chk("async_rst_valid_msb", 32'(out_valid1), 0);
    chk("async_rst_ready", 32'(in_ready0), 1);
    chk("async_rst_count", 32'(count0), 0);
    chk("async_rst_code", 32'(code0), 0);
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_no_done", done_cnt - d0, 0);
    rv = '{16'h0002, 1, 0, 1'b0};
    run_vec(rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
